gray_seq_ctrl: RTL and testbench

Sequencer for the 4-bit Gray counter datapath: on a start handshake it loads a binary start value and runs a programmed number of Gray-code steps, up or down. Steps can be slowed by a prescaler, frozen by hold, or cancelled by abort. It presents the current Gray code, a per-step strobe, busy, and a one-cycle done pulse. It sits between a host/config register block and any Gray-coded consumer, such as a position encoder emulator or clock-domain pointer.

---
 rtl/gray_seq_pkg.sv | 20 ++
 rtl/gray_seq_ctrl_if.sv | 27 ++
 rtl/gray_seq_ctrl_bin2gray.sv | 13 +
 rtl/gray_seq_ctrl.sv | 103 ++++++++++
 tb/tb_gray_seq_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray-code sequencer.
package gray_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest code the helper supports; callers zero-extend and truncate to WIDTH.
  localparam int GSEQ_MAX_WIDTH = 32;

  // Binary to reflected Gray code. Zero-extension leaves the low WIDTH bits
  // identical to a native WIDTH-bit conversion, so one function serves every WIDTH.
  function automatic logic [GSEQ_MAX_WIDTH-1:0] bin_to_gray(input logic [GSEQ_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// Host-side handshake and status bundle of the Gray sequencer.
interface gray_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] len;
  logic             dir;
  logic             hold;
  logic             abort;
  logic [WIDTH-1:0] gray_out;
  logic             step;
  logic             busy;
  logic             done;

  // Host / config block side
  modport master (
    output start, start_val, len, dir, hold, abort,
    input  gray_out, step, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, start_val, len, dir, hold, abort,
    output gray_out, step, busy, done
  );
endinterface

// File: rtl/gray_seq_ctrl_bin2gray.sv
// Combinational binary-to-Gray converter feeding the gray_out register.
module bin2gray
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = WIDTH'(bin_to_gray(GSEQ_MAX_WIDTH'(i_bin)));

endmodule

// File: rtl/gray_seq_ctrl.sv
// Gray-code step sequencer: loads a start value, then runs len prescaled
// up/down steps with hold/abort, emitting gray_out, step, busy and done.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input logic          clk,
  input logic          rst,
  gray_seq_ctrl_if.slave bus
);

  localparam int            PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] r_gray;
  logic [WIDTH-1:0] w_gray_next;
  logic [WIDTH-1:0] r_remaining;
  logic [PW-1:0]    r_presc;
  logic             r_dir;
  logic             r_step;
  logic             w_load;
  logic             w_advance;
  logic             w_tick;

  // A start is honoured only outside RUN; it beats abort there.
  assign w_load    = (r_state != RUN) && bus.start;
  // Prescaler moves only on un-held, un-aborted RUN edges.
  assign w_advance = (r_state == RUN) && !bus.abort && !bus.hold;
  assign w_tick    = w_advance && (r_presc == PRESC_LAST);

  // Binary count after this edge; the Gray register always follows it.
  assign w_bin_next = w_load ? bus.start_val :
                      w_tick ? (r_dir ? r_bin + WIDTH'(1) : r_bin - WIDTH'(1)) :
                      r_bin;

  bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
    .i_bin  (w_bin_next),
    .o_gray (w_gray_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state logic: abort dominates in RUN, last tick finishes the run.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start)            w_state_next = (bus.len != '0) ? RUN : DONE;
        else                      w_state_next = IDLE;
      end
      RUN: begin
        if (bus.abort)            w_state_next = IDLE;
        else if (w_tick && r_remaining == WIDTH'(1)) w_state_next = DONE;
      end
      default:                    w_state_next = IDLE;
    endcase
  end

  // Datapath: binary/Gray counters, remaining-step count, prescaler, step strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bin       <= '0;
      r_gray      <= '0;
      r_remaining <= '0;
      r_presc     <= '0;
      r_dir       <= 1'b0;
      r_step      <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_step <= w_tick;
      if (w_load) begin
        r_remaining <= bus.len;
        r_presc     <= '0;
        r_dir       <= bus.dir;
      end else if (w_tick) begin
        r_remaining <= r_remaining - WIDTH'(1);
        r_presc     <= '0;
      end else if (w_advance) begin
        r_presc     <= r_presc + PW'(1);
      end
    end
  end

  // Outputs: busy/done decode the state, code and strobe come from registers.
  always_comb begin
    bus.busy     = (r_state == RUN);
    bus.done     = (r_state == DONE);
    bus.gray_out = r_gray;
    bus.step     = r_step;
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Bench for gray_seq_ctrl: two instances (PRESCALE 1 and 3) share stimulus;
// a step-schedule model checks both every cycle, directed checks pin literals.
module tb_gray_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, dir, hold, abort;
  logic [3:0] start_val, len;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gray_seq_ctrl_if #(.WIDTH(4)) bus1 ();
  gray_seq_ctrl_if #(.WIDTH(4)) bus3 ();

  assign bus1.start = start;  assign bus1.start_val = start_val;  assign bus1.len = len;
  assign bus1.dir   = dir;    assign bus1.hold      = hold;       assign bus1.abort = abort;
  assign bus3.start = start;  assign bus3.start_val = start_val;  assign bus3.len = len;
  assign bus3.dir   = dir;    assign bus3.hold      = hold;       assign bus3.abort = abort;

  gray_seq_ctrl #(.WIDTH(4), .PRESCALE(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  gray_seq_ctrl #(.WIDTH(4), .PRESCALE(3)) u3 (.clk(clk), .rst(rst), .bus(bus3));

  logic [3:0] dg [2];
  logic       ds [2];
  logic       db [2];
  logic       dd [2];
  assign dg[0] = bus1.gray_out; assign ds[0] = bus1.step; assign db[0] = bus1.busy; assign dd[0] = bus1.done;
  assign dg[1] = bus3.gray_out; assign ds[1] = bus3.step; assign db[1] = bus3.busy; assign dd[1] = bus3.done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gray(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  // Model: phase 0=idle 1=running 2=finished; wait counts cycles to next step.
  int pv [2] = '{1, 3};
  int m_phase [2], m_bin [2], m_left [2], m_wait [2], m_up [2], m_step [2];

  task automatic model_edge(input int i);
    if (!rst) begin
      m_phase[i] = 0; m_bin[i] = 0; m_left[i] = 0; m_step[i] = 0;
    end else begin
      m_step[i] = 0;
      if (m_phase[i] != 1) begin
        if (start) begin
          m_bin[i]   = int'(start_val);
          m_left[i]  = int'(len);
          m_up[i]    = int'(dir);
          m_wait[i]  = pv[i];
          m_phase[i] = (len != 0) ? 1 : 2;
        end else begin
          m_phase[i] = 0;
        end
      end else if (abort) begin
        m_phase[i] = 0;
      end else if (!hold) begin
        m_wait[i]--;
        if (m_wait[i] == 0) begin
          m_bin[i]  = m_up[i] != 0 ? (m_bin[i] + 1) % 16 : (m_bin[i] + 15) % 16;
          m_left[i]--;
          m_step[i] = 1;
          m_wait[i] = pv[i];
          if (m_left[i] == 0) m_phase[i] = 2;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) model_edge(i);
  end

  // Per-cycle comparison against the model, plus the single-bit-change rule.
  logic [3:0] prev_g [2];
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("cyc_gray%0d", i), 32'(dg[i]), 32'(gray(m_bin[i])));
      chk($sformatf("cyc_step%0d", i), 32'(ds[i]), 32'(m_step[i]));
      chk($sformatf("cyc_busy%0d", i), 32'(db[i]), 32'(m_phase[i] == 1));
      chk($sformatf("cyc_done%0d", i), 32'(dd[i]), 32'(m_phase[i] == 2));
      if (ds[i] === 1'b1)
        chk($sformatf("onebit%0d", i), 32'($countones(prev_g[i] ^ dg[i])), 32'd1);
      prev_g[i] = dg[i];
    end
  end

  task automatic go(input int sv, input int l, input int d);
    start = 1'b1; start_val = 4'(sv); len = 4'(l); dir = d[0];
    @(negedge clk);
    start = 1'b0;
  endtask

  int seq1 [6] = '{0, 1, 3, 2, 6, 7};
  int seq2 [3] = '{0, 8, 9};
  int seq3 [4] = '{9, 8, 0, 1};
  int done_c, st1_c, st2_c;

  initial begin
    rst = 1'b0; start = 0; dir = 0; hold = 0; abort = 0; start_val = 0; len = 0;
    repeat (3) @(negedge clk);
    chk("rst_gray", 32'(bus1.gray_out), 0);
    chk("rst_busy", 32'(bus1.busy), 0);
    rst = 1'b1;
    @(negedge clk);

    // Up count from 0, five steps
    go(0, 5, 1);
    for (int k = 0; k < 6; k++) begin
      chk("t1_gray", 32'(bus1.gray_out), 32'(seq1[k]));
      if (k > 0) chk("t1_step", 32'(bus1.step), 1);
      chk("t1_done", 32'(bus1.done), 32'(k == 5));
      @(negedge clk);
    end
    chk("t1_idle_busy", 32'(bus1.busy), 0);

    // Down count wraps 0 -> 15
    go(0, 2, 0);
    for (int k = 0; k < 3; k++) begin
      chk("t2_gray", 32'(bus1.gray_out), 32'(seq2[k]));
      chk("t2_done", 32'(bus1.done), 32'(k == 2));
      @(negedge clk);
    end

    // Up count wraps 15 -> 0; restart straight out of DONE
    go(14, 3, 1);
    for (int k = 0; k < 4; k++) begin
      chk("t3_gray", 32'(bus1.gray_out), 32'(seq3[k]));
      chk("t3_done", 32'(bus1.done), 32'(k == 3));
      if (k < 3) @(negedge clk);
    end
    go(1, 1, 1);
    chk("t3r_gray", 32'(bus1.gray_out), 1);
    chk("t3r_busy", 32'(bus1.busy), 1);
    @(negedge clk);
    chk("t3r_gray2", 32'(bus1.gray_out), 3);
    chk("t3r_done", 32'(bus1.done), 1);
    repeat (40) @(negedge clk);

    // Prescale 3 with a 4-cycle hold between the steps
    done_c = -1; st1_c = -1; st2_c = -1;
    go(0, 2, 1);
    for (int c = 0; c < 20; c++) begin
      if (bus3.step === 1'b1) begin
        if (st1_c < 0) st1_c = c; else if (st2_c < 0) st2_c = c;
      end
      if (bus3.done === 1'b1 && done_c < 0) done_c = c;
      if (c == 3) hold = 1'b1;
      if (c == 7) hold = 1'b0;
      @(negedge clk);
    end
    chk("t4_step1_cyc", 32'(st1_c), 3);
    chk("t4_step2_cyc", 32'(st2_c), 10);
    chk("t4_done_cyc", 32'(done_c), 10);

    // Abort after two steps; a start during RUN is ignored
    go(3, 6, 1);
    @(negedge clk);
    start = 1'b1; start_val = 4'd9; len = 4'd1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_step2", 32'(bus1.step), 1);
    chk("t5_gray2", 32'(bus1.gray_out), 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_busy", 32'(bus1.busy), 0);
    chk("t5_step", 32'(bus1.step), 0);
    for (int c = 0; c < 3; c++) begin
      chk("t5_frozen", 32'(bus1.gray_out), 7);
      chk("t5_nodone", 32'(bus1.done), 0);
      @(negedge clk);
    end

    // len=0 with abort asserted in IDLE: start wins, done next cycle, no step
    start = 1'b1; abort = 1'b1; len = 4'd0; start_val = 4'd6;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("t6_done", 32'(bus1.done), 1);
    chk("t6_busy", 32'(bus1.busy), 0);
    chk("t6_step", 32'(bus1.step), 0);
    chk("t6_gray", 32'(bus1.gray_out), 5);
    @(negedge clk);
    chk("t6_done_off", 32'(bus1.done), 0);

    // Reset mid-run, then a normal run
    go(0, 8, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t7_gray", 32'(bus1.gray_out), 0);
    chk("t7_busy", 32'(bus1.busy), 0);
    chk("t7_step", 32'(bus1.step), 0);
    chk("t7_gray3", 32'(bus3.gray_out), 0);
    rst = 1'b1;
    @(negedge clk);
    go(5, 1, 0);
    chk("t7_load_gray", 32'(bus1.gray_out), 7);
    chk("t7_load_busy", 32'(bus1.busy), 1);
    @(negedge clk);
    chk("t7_end_gray", 32'(bus1.gray_out), 6);
    chk("t7_end_done", 32'(bus1.done), 1);
    chk("t7_end_step", 32'(bus1.step), 1);
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
